mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, the address width of all ports.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have i_valid, input, 1: instruction fetch request.
REQ-005 SHALL have i_addr, input, ADDR_W: fetch address.
REQ-006 SHALL have i_ok, output, 1: fetch completion pulse.
REQ-007 SHALL have i_data, output, 32: fetched instruction.
REQ-008 SHALL have d_valid, input, 1: data access request.
REQ-009 SHALL have d_addr, input, ADDR_W: data address.
REQ-010 SHALL have d_size, input, 3: access size code.
REQ-011 SHALL have d_strobe, input, 8: byte write enables; 0 means read.
REQ-012 SHALL have d_wdata, input, 64: store data.
REQ-013 SHALL have d_ok, output, 1: data completion pulse.
REQ-014 SHALL have d_data, output, 64: load data.
REQ-015 SHALL have m_valid, output, 1: shared memory port request.
REQ-016 SHALL have m_addr (ADDR_W), m_size (3), m_strobe (8) and m_wdata (64) as outputs: forwarded request fields.
REQ-017 SHALL have m_ok, input, 1: memory completion; m_data, input, 64: memory read data.

Function
REQ-018 SHALL implement states IDLE, GRANT_I and GRANT_D.
REQ-019 In IDLE with d_valid=1, the next state SHALL be GRANT_D; with only i_valid=1, GRANT_I; with neither, IDLE.
REQ-020 When both requests are valid in IDLE, selection SHALL follow REQ-030/031.
REQ-021 In GRANT_x, m_valid SHALL be 1 and the m_* fields SHALL combinationally mirror requester x; for GRANT_I: m_size=3'b010, m_strobe=0, m_wdata=0.
REQ-022 In IDLE, m_valid, m_addr, m_size, m_strobe and m_wdata SHALL all be 0.
REQ-023 In GRANT_x with m_ok=1, x_ok SHALL be 1 in the same cycle, the other ok SHALL be 0, and the state SHALL return to IDLE at the next edge.
REQ-024 i_data SHALL be m_data[63:32] when i_addr[2]=1, else m_data[31:0]; d_data SHALL be m_data; both SHALL be 0 unless the matching ok is 1.
REQ-025 Request-to-m_valid latency SHALL be 1 cycle; m_valid SHALL drop for at least 1 idle cycle between back-to-back transactions.
REQ-026 Requesters hold valid and fields stable until their ok; a requester's valid dropping while granted SHALL NOT abort the grant (state held until m_ok).
REQ-027 m_ok in IDLE SHALL be ignored, and i_ok and d_ok SHALL stay 0.

Reset
REQ-028 On reset=1 at a clock edge, the state SHALL become IDLE, including mid-transaction, and the priority pointer SHALL become "D preferred".
REQ-029 While in IDLE, all outputs SHALL be 0, including the cycle after reset.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, on a tie the requester not granted last SHALL win; the pointer SHALL update on each completed (m_ok) transaction.
REQ-031 Without ARB_ROUND_ROBIN_EN, D SHALL always win ties (fixed priority), and no pointer register SHALL exist.

Verification
REQ-032 Reset, then i_valid=1 with i_addr=0x80000004 and m_data=0x11112222_33334444 on m_ok at cycle 3 -> m_valid rises at cycle 1 and i_ok=1, i_data=0x11112222 at cycle 3.
REQ-033 i_valid=d_valid=1 simultaneously with the macro undefined -> D granted, d_ok first; I granted after 1 idle cycle; total 2 transactions.
REQ-034 Same stimulus with ARB_ROUND_ROBIN_EN defined, repeated 4 times -> grants alternate D, I, D, I...; no starvation.
REQ-035 Store d_strobe=0xFF, d_wdata=0xDEADBEEF_00C0FFEE, d_addr=0x100 -> the m_* fields match exactly while granted, and i_ok stays 0.
REQ-036 reset asserted during GRANT_D before m_ok -> next cycle IDLE, all outputs 0, a late m_ok produces no ok pulse.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Groups the three buses around mem_bus_arbiter:
//     i_*  instruction-fetch requester (valid/addr in, ok/data out)
//     d_*  data requester (valid/addr/size/strobe/wdata in, ok/data out)
//     m_*  shared memory port (valid/addr/size/strobe/wdata out, ok/data in)
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the memory port)
//     master - the surrounding system's view (requesters plus memory)
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ok;
  logic [31:0]       i_data;

  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [7:0]        d_strobe;
  logic [63:0]       d_wdata;
  logic              d_ok;
  logic [63:0]       d_data;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [7:0]        m_strobe;
  logic [63:0]       m_wdata;
  logic              m_ok;
  logic [63:0]       m_data;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
           m_ok, m_data,
    output i_ok, i_data, d_ok, d_data,
           m_valid, m_addr, m_size, m_strobe, m_wdata
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
           m_ok, m_data,
    input  i_ok, i_data, d_ok, d_data,
           m_valid, m_addr, m_size, m_strobe, m_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between an instruction-fetch requester (I) and a
//   data requester (D). A request seen in IDLE is granted at the next edge;
//   the grant is held until m_ok, then the arbiter returns to IDLE for at
//   least one cycle. While granted, the m_* fields and the requester's ok/data
//   follow the bus combinationally so completion is reported in the m_ok cycle.
//   Ports:
//     clk    - clock, all state on posedge
//     reset  - synchronous, active-high; forces IDLE and "D preferred"
//     bus    - mem_bus_arbiter_if.slave (i_*, d_*, m_* signals)
//   Configuration:
//     ARB_ROUND_ROBIN_EN - when defined, ties alternate using a pointer that
//                          favours the requester not served last; otherwise
//                          D always wins ties and no pointer exists.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 64
) (
  input logic             clk,
  input logic             reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            state;
  logic              pick_d;
  logic [ADDR_W-1:0] addr_mux;

`ifdef ARB_ROUND_ROBIN_EN
  logic prefer_d;

  always_comb pick_d = bus.d_valid && (!bus.i_valid || prefer_d);

  // Pointer moves only on completed transfers, so an aborted grant
  // (reset mid-transaction) does not count as a turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_d <= 1'b1;
    end else if (bus.m_ok) begin
      if (state == GRANT_D) prefer_d <= 1'b0;
      else if (state == GRANT_I) prefer_d <= 1'b1;
    end
  end
`else
  always_comb pick_d = bus.d_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d)           state <= GRANT_D;
          else if (bus.i_valid) state <= GRANT_I;
        end
        // Requester valid is not re-checked: only m_ok ends a grant.
        GRANT_I: if (bus.m_ok) state <= IDLE;
        GRANT_D: if (bus.m_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.m_valid  = 1'b0;
    addr_mux     = '0;
    bus.m_size   = '0;
    bus.m_strobe = '0;
    bus.m_wdata  = '0;
    bus.i_ok     = 1'b0;
    bus.i_data   = '0;
    bus.d_ok     = 1'b0;
    bus.d_data   = '0;
    case (state)
      GRANT_I: begin
        bus.m_valid = 1'b1;
        addr_mux    = bus.i_addr;
        bus.m_size  = 3'b010;
        bus.i_ok    = bus.m_ok;
        // Fetch returns the 32-bit half selected by address bit 2.
        if (bus.m_ok)
          bus.i_data = bus.i_addr[2] ? bus.m_data[63:32] : bus.m_data[31:0];
      end
      GRANT_D: begin
        bus.m_valid  = 1'b1;
        addr_mux     = bus.d_addr;
        bus.m_size   = bus.d_size;
        bus.m_strobe = bus.d_strobe;
        bus.m_wdata  = bus.d_wdata;
        bus.d_ok     = bus.m_ok;
        if (bus.m_ok) bus.d_data = bus.m_data;
      end
      default: ;
    endcase
  end

  assign bus.m_addr = addr_mux;

endmodule
